// File: rtl/gpio_seq_pkg.sv
// Shared types and helpers for the GPIO pattern sequencer.
// Commands are packed {delay, mask, oe, out}, so an entry is 3*N_GPIO + DELAY_W bits wide.
package gpio_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } seq_state_t;

  localparam int N_GPIO_DEF  = 8;
  localparam int DEPTH_DEF   = 4;
  localparam int DELAY_W_DEF = 16;

  function automatic int entry_width(input int n_gpio, input int delay_w);
    return 3 * n_gpio + delay_w;
  endfunction

endpackage

// File: rtl/gpio_seq_fifo.sv
// Synchronous FIFO with flush. A push becomes visible at the head one cycle after the push edge.
// Backpressure: full blocks push, empty blocks pop, and flush overrides both.
module gpio_seq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_en;
  logic             pop_en;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign push_en = push && !full && !flush;
  assign pop_en  = pop && !empty && !flush;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers wrap naturally at DEPTH; the extra level bit separates full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push_en && !pop_en) begin
        level <= level + (AW+1)'(1);
      end else if (pop_en && !push_en) begin
        level <= level - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/gpio_seq.sv
// Timed GPIO sequencer: applies masked out/oe updates from a command FIFO, each held for delay+1 cycles.
// Latency: a command reaches seq_out one edge after its push edge; cmd_ready drops while full or aborting.
module gpio_seq
  import gpio_seq_pkg::*;
#(
  parameter int N_GPIO  = N_GPIO_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int DELAY_W = DELAY_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     abort,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [N_GPIO-1:0]        cmd_out,
  input  logic [N_GPIO-1:0]        cmd_oe,
  input  logic [N_GPIO-1:0]        cmd_mask,
  input  logic [DELAY_W-1:0]       cmd_delay,
  output logic [N_GPIO-1:0]        seq_out,
  output logic [N_GPIO-1:0]        seq_oe,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drained
);

  localparam int EW = entry_width(N_GPIO, DELAY_W);

  typedef struct packed {
    logic [DELAY_W-1:0] delay;
    logic [N_GPIO-1:0]  mask;
    logic [N_GPIO-1:0]  oe;
    logic [N_GPIO-1:0]  out;
  } cmd_t;

  cmd_t               push_dat;
  cmd_t               head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push_vld;
  logic               pop_ok;
  logic               pop_vld;
  seq_state_t         state;
  logic [DELAY_W-1:0] count;

  function automatic logic [N_GPIO-1:0] merge(input logic [N_GPIO-1:0] cur,
                                               input logic [N_GPIO-1:0] nxt,
                                               input logic [N_GPIO-1:0] msk);
    return (cur & ~msk) | (nxt & msk);
  endfunction

  assign push_dat  = '{delay: cmd_delay, mask: cmd_mask, oe: cmd_oe, out: cmd_out};
  assign cmd_ready = !fifo_full && !abort;
  assign push_vld  = cmd_valid && cmd_ready;
  assign pop_ok    = enable && !fifo_empty && !abort;
  // A new command is taken from IDLE, or back-to-back once the current hold has expired.
  assign pop_vld   = pop_ok && ((state == IDLE) || (count == '0));
  assign busy      = (state == HOLD);

  gpio_seq_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_vld),
    .push_dat (push_dat),
    .pop      (pop_vld),
    .flush    (abort),
    .pop_dat  (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      seq_out <= '0;
      seq_oe  <= '0;
      drained <= 1'b0;
    end else begin
      drained <= 1'b0;
      if (abort) begin
        state <= IDLE;
        count <= '0;
      end else if (pop_vld) begin
        seq_out <= merge(seq_out, head.out, head.mask);
        seq_oe  <= merge(seq_oe, head.oe, head.mask);
        count   <= head.delay;
        state   <= HOLD;
      end else if (state == HOLD) begin
        if (count != '0) begin
          count <= count - DELAY_W'(1);
        end else begin
          state   <= IDLE;
          drained <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gpio_seq.sv
// Bench for gpio_seq: table of single commands, hand-written corner sequences, then random traffic
// checked against a queue-and-timestamp reference model.
module tb_gpio_seq;

  localparam int N   = 8;
  localparam int DEP = 4;
  localparam int DW  = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          abort;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [N-1:0]  cmd_out;
  logic [N-1:0]  cmd_oe;
  logic [N-1:0]  cmd_mask;
  logic [DW-1:0] cmd_delay;
  logic [N-1:0]  seq_out;
  logic [N-1:0]  seq_oe;
  logic          busy;
  logic [$clog2(DEP):0] level;
  logic          drained;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  gpio_seq #(.N_GPIO(N), .DEPTH(DEP), .DELAY_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .abort     (abort),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_out   (cmd_out),
    .cmd_oe    (cmd_oe),
    .cmd_mask  (cmd_mask),
    .cmd_delay (cmd_delay),
    .seq_out   (seq_out),
    .seq_oe    (seq_oe),
    .busy      (busy),
    .level     (level),
    .drained   (drained)
  );

  typedef struct {
    logic [7:0]  out;
    logic [7:0]  oe;
    logic [7:0]  mask;
    logic [15:0] delay;
    logic [7:0]  exp_out;
    logic [7:0]  exp_oe;
  } vec_t;

  typedef struct packed {
    logic [7:0]  o;
    logic [7:0]  e;
    logic [7:0]  m;
    logic [15:0] d;
  } mcmd_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_cmd(input logic [7:0] o, input logic [7:0] e, input logic [7:0] m,
                         input logic [15:0] d);
    cmd_out   = o;
    cmd_oe    = e;
    cmd_mask  = m;
    cmd_delay = d;
  endtask

  // All tasks start and end just after a falling edge.
  task automatic do_reset;
    rst_n     = 1'b0;
    enable    = 1'b0;
    abort     = 1'b0;
    cmd_valid = 1'b0;
    set_cmd(8'h00, 8'h00, 8'h00, 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic push_cmd(input logic [7:0] o, input logic [7:0] e, input logic [7:0] m,
                          input logic [15:0] d);
    logic rdy;
    rdy = 1'b0;
    set_cmd(o, e, m, d);
    cmd_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      rdy = cmd_ready;
      @(negedge clk);
      if (rdy) break;
    end
    cmd_valid = 1'b0;
    chk("push_accept", 32'(rdy), 32'd1);
  endtask

  vec_t vecs[7];

  initial begin
    int hold;
    int ndr;
    logic [7:0] exp_seq[4];

    vecs[0] = '{8'hFF, 8'h0F, 8'h0F, 16'd0, 8'h0F, 8'h0F};
    vecs[1] = '{8'h00, 8'hFF, 8'hF0, 16'd1, 8'h0F, 8'hFF};
    vecs[2] = '{8'hAA, 8'h55, 8'h3C, 16'd2, 8'h2B, 8'hD7};
    vecs[3] = '{8'h55, 8'h00, 8'h00, 16'd3, 8'h2B, 8'hD7};
    vecs[4] = '{8'h80, 8'h80, 8'h81, 16'd0, 8'hAA, 8'hD6};
    vecs[5] = '{8'h00, 8'h00, 8'hFF, 16'd0, 8'h00, 8'h00};
    vecs[6] = '{8'hA5, 8'hFF, 8'hFF, 16'd3, 8'hA5, 8'hFF};

    // Reset state
    do_reset();
    chk("rst_out", 32'(seq_out), 32'h00);
    chk("rst_oe", 32'(seq_oe), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_drained", 32'(drained), 32'd0);

    // Single commands from idle, cumulative masked effect
    enable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      push_cmd(vecs[i].out, vecs[i].oe, vecs[i].mask, vecs[i].delay);
      chk("vec_level_after_push", 32'(level), 32'd1);
      @(negedge clk);
      chk("vec_out", 32'(seq_out), 32'(vecs[i].exp_out));
      chk("vec_oe", 32'(seq_oe), 32'(vecs[i].exp_oe));
      hold = busy ? 1 : 0;
      for (int k = 0; k < 300; k++) begin
        @(negedge clk);
        if (busy) hold++;
        else break;
      end
      chk("vec_hold", 32'(hold), 32'(vecs[i].delay) + 32'd1);
      chk("vec_drained", 32'(drained), 32'd1);
      @(negedge clk);
      chk("vec_drained_once", 32'(drained), 32'd0);
      chk("vec_out_kept", 32'(seq_out), 32'(vecs[i].exp_out));
    end

    // Masked back-to-back from a preloaded queue
    do_reset();
    push_cmd(8'h01, 8'hFF, 8'h01, 16'd0);
    push_cmd(8'h00, 8'hFF, 8'h01, 16'd0);
    push_cmd(8'h80, 8'hFF, 8'h80, 16'd1);
    chk("b2b_level", 32'(level), 32'd3);
    exp_seq[0] = 8'h01;
    exp_seq[1] = 8'h00;
    exp_seq[2] = 8'h80;
    exp_seq[3] = 8'h80;
    enable = 1'b1;
    ndr = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("b2b_out", 32'(seq_out), 32'(exp_seq[i]));
      chk("b2b_busy", 32'(busy), 32'd1);
      ndr += int'(drained);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ndr += int'(drained);
    end
    chk("b2b_drained_count", 32'(ndr), 32'd1);
    chk("b2b_out_final", 32'(seq_out), 32'h80);

    // Backpressure: fifth push waits for the first pop
    do_reset();
    for (int i = 0; i < 4; i++) push_cmd(8'(i + 1), 8'hFF, 8'hFF, 16'd5);
    chk("bp_level_full", 32'(level), 32'd4);
    chk("bp_ready_full", 32'(cmd_ready), 32'd0);
    set_cmd(8'h55, 8'hFF, 8'hFF, 16'd5);
    cmd_valid = 1'b1;
    enable    = 1'b1;
    @(negedge clk);
    chk("bp_level_after_pop", 32'(level), 32'd3);
    chk("bp_ready_after_pop", 32'(cmd_ready), 32'd1);
    chk("bp_first_out", 32'(seq_out), 32'h01);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("bp_level_after_push", 32'(level), 32'd4);

    // Abort during a long hold
    do_reset();
    enable = 1'b1;
    push_cmd(8'h3C, 8'hFF, 8'hFF, 16'd100);
    push_cmd(8'h11, 8'hFF, 8'hFF, 16'd0);
    push_cmd(8'h22, 8'hFF, 8'hFF, 16'd0);
    repeat (8) @(negedge clk);
    chk("ab_busy_before", 32'(busy), 32'd1);
    chk("ab_level_before", 32'(level), 32'd2);
    set_cmd(8'hFF, 8'hFF, 8'hFF, 16'd0);
    cmd_valid = 1'b1;
    abort     = 1'b1;
    #1;
    chk("ab_ready_low", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    abort     = 1'b0;
    cmd_valid = 1'b0;
    chk("ab_level", 32'(level), 32'd0);
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_drained", 32'(drained), 32'd0);
    chk("ab_out", 32'(seq_out), 32'h3C);
    chk("ab_oe", 32'(seq_oe), 32'hFF);
    ndr = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ndr += int'(drained);
    end
    chk("ab_no_drain_later", 32'(ndr), 32'd0);
    chk("ab_level_later", 32'(level), 32'd0);

    // Enable dropped during the first hold
    do_reset();
    push_cmd(8'h11, 8'hFF, 8'hFF, 16'd2);
    push_cmd(8'h22, 8'hFF, 8'hFF, 16'd2);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    chk("en_first_out", 32'(seq_out), 32'h11);
    ndr = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("en_busy_hold", 32'(busy), 32'd1);
      ndr += int'(drained);
    end
    @(negedge clk);
    chk("en_drained", 32'(drained), 32'd1);
    chk("en_no_early_drain", 32'(ndr), 32'd0);
    chk("en_busy_done", 32'(busy), 32'd0);
    chk("en_level_kept", 32'(level), 32'd1);
    chk("en_out_kept", 32'(seq_out), 32'h11);
    @(negedge clk);
    chk("en_idle_stays", 32'(seq_out), 32'h11);
    enable = 1'b1;
    @(negedge clk);
    chk("en_second_out", 32'(seq_out), 32'h22);
    chk("en_second_level", 32'(level), 32'd0);

    // Random traffic against the reference model
    begin
      mcmd_t      q[$];
      mcmd_t      c;
      logic [7:0] m_out;
      logic [7:0] m_oe;
      logic       m_act;
      int         m_free;
      logic       exp_dr;
      logic       exp_rdy;
      logic       acc;

      do_reset();
      m_out  = 8'h00;
      m_oe   = 8'h00;
      m_act  = 1'b0;
      m_free = 0;
      acc    = 1'b1;
      enable = 1'b1;
      for (int cyc = 0; cyc < 2000; cyc++) begin
        if (!cmd_valid || acc) begin
          cmd_valid = ($urandom_range(0, 1) == 1);
          set_cmd(8'($urandom), 8'($urandom), 8'($urandom), 16'($urandom_range(0, 4)));
        end
        if ($urandom_range(0, 7) == 0) enable = ~enable;
        abort = ($urandom_range(0, 63) == 0);
        #1;
        exp_rdy = (q.size() < DEP) && !abort;
        chk("rnd_ready", 32'(cmd_ready), 32'(exp_rdy));
        acc    = cmd_valid && exp_rdy;
        exp_dr = 1'b0;
        if (abort) begin
          q.delete();
          m_act = 1'b0;
        end else begin
          if (enable && q.size() > 0 && (!m_act || cyc >= m_free)) begin
            c      = q.pop_front();
            m_out  = (m_out & ~c.m) | (c.o & c.m);
            m_oe   = (m_oe & ~c.m) | (c.e & c.m);
            m_free = cyc + int'(c.d) + 1;
            m_act  = 1'b1;
          end else if (m_act && cyc >= m_free) begin
            m_act  = 1'b0;
            exp_dr = 1'b1;
          end
          if (acc) q.push_back({cmd_out, cmd_oe, cmd_mask, cmd_delay});
        end
        @(negedge clk);
        chk("rnd_out", 32'(seq_out), 32'(m_out));
        chk("rnd_oe", 32'(seq_oe), 32'(m_oe));
        chk("rnd_level", 32'(level), 32'(q.size()));
        chk("rnd_busy", 32'(busy), 32'(m_act));
        chk("rnd_drained", 32'(drained), 32'(exp_dr));
      end
      abort     = 1'b0;
      cmd_valid = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
